usr_shift_sequencer: RTL and testbench

//  Sequential front-end for the combinational 8-bit universal shift stage.

---
 rtl/usr_pkg.sv | 26 ++
 rtl/usr_shift_step.sv | 33 +++
 rtl/usr_shift_sequencer.sv | 84 ++++++++
 tb/tb_usr_shift_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift sequencer: op modes, FSM states, defaults.
// Pure declarations; no clocked logic, no backpressure.
package usr_pkg;

  localparam int USR_WIDTH_DEF = 8;
  localparam int USR_CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_HOLD = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } usr_seq_state_t;

  // Only the two shift modes iterate; hold and load finish immediately.
  function automatic logic usr_is_shift(input usr_mode_t mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR);
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One-bit universal shift stage, purely combinational (zero latency, no backpressure).
// USR_ROTATE_EN selects rotate instead of zero-fill for the vacated bit.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] d,
  input  usr_mode_t        mode,
  output logic [WIDTH-1:0] q
);

  logic fill_left;
  logic fill_right;

`ifdef USR_ROTATE_EN
  assign fill_left  = d[WIDTH-1];
  assign fill_right = d[0];
`else
  assign fill_left  = 1'b0;
  assign fill_right = 1'b0;
`endif

  always_comb begin
    q = d;
    case (mode)
      MODE_SHL: q = {d[WIDTH-2:0], fill_left};
      MODE_SHR: q = {fill_right, d[WIDTH-1:1]};
      default:  q = d;
    endcase
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Iterates usr_shift_step once per clock for in_count steps; result N+1 cycles after accept (N=0 for hold/load).
// in_ready low outside IDLE; result held on out_data until out_ready. USR_ROTATE_EN selects rotate shifts.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEF,
  parameter int CNT_W = USR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  usr_seq_state_t   state;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  usr_mode_t        mode_q;
  logic [WIDTH-1:0] step_q;
  usr_mode_t        in_mode_t;
  logic             accept;

  assign in_mode_t = usr_mode_t'(in_mode);

  // rst_n gating keeps in_ready low while reset is held, not just after release.
  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? data_q : '0;
  assign busy      = (state != IDLE);

  usr_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .d    (data_q),
    .mode (mode_q),
    .q    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_SHL;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= in_data;
            mode_q <= in_mode_t;
            cnt_q  <= in_count;
            if (usr_is_shift(in_mode_t) && (in_count != '0)) begin
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          data_q <= step_q;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Randomized bench for usr_shift_sequencer against an arithmetic reference of the shift rules.
// Covers directed corner ops, result stalls with a pending op, and a reset mid-shift.
module tb_usr_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_mode = 2'b00;
  logic [CNT_W-1:0] in_count = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  usr_shift_sequencer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of shifting d by c single-bit steps, computed in one go.
  function automatic logic [7:0] ref_result(input logic [7:0] d, input logic [1:0] m, input int c);
    int v;
    int r;
    v = d;
    r = c % 8;
    case (m)
`ifdef USR_ROTATE_EN
      2'b00: v = ((v << r) | (v >> (8 - r))) & 255;
      2'b10: v = ((v >> r) | (v << (8 - r))) & 255;
`else
      2'b00: v = (c >= 8) ? 0 : ((v << c) & 255);
      2'b10: v = (c >= 8) ? 0 : (v >> c);
`endif
      default: v = d;
    endcase
    return v[7:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] m, input int c);
    return (m == 2'b00 || m == 2'b10) ? c : 0;
  endfunction

  task automatic drive(input logic [7:0] d, input logic [1:0] m, input logic [3:0] c, input logic v);
    in_data  = d;
    in_mode  = m;
    in_count = c;
    in_valid = v;
  endtask

  // Runs one op from the current negedge; during the result stall the next op is presented.
  task automatic run_op(input logic [7:0] d, input logic [1:0] m, input logic [3:0] c, input int stall,
                        input logic [7:0] nd, input logic [1:0] nm, input logic [3:0] nc, input logic nv);
    int w;
    int lat;
    logic [7:0] exp_d;
    exp_d = ref_result(d, m, int'(c));
    w = 0;
    drive(d, m, c, 1'b1);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", (w < 50), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("busy_shift", busy, 1);
      chk("out_data_zero", out_data, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, ref_latency(m, int'(c)));
    chk("result", out_data, exp_d);
    chk("busy_done", busy, 1);
    chk("in_ready_done", in_ready, 0);
    drive(nd, nm, nc, nv);
    out_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp_d);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_data", out_data, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] cd;
    logic [1:0] cm;
    logic [3:0] cc;
    logic [7:0] nd;
    logic [1:0] nm;
    logic [3:0] nc;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);

    run_op(8'hDA, 2'b00, 4'd1, 0, 8'h00, 2'b00, 4'd0, 1'b0);
    run_op(8'hDA, 2'b10, 4'd3, 1, 8'h00, 2'b00, 4'd0, 1'b0);
    run_op(8'hDA, 2'b01, 4'd5, 0, 8'h00, 2'b00, 4'd0, 1'b0);
    run_op(8'hF0, 2'b11, 4'd7, 2, 8'h00, 2'b00, 4'd0, 1'b0);
    run_op(8'hF0, 2'b00, 4'd9, 0, 8'h00, 2'b00, 4'd0, 1'b0);
    run_op(8'hA5, 2'b10, 4'd15, 0, 8'h00, 2'b00, 4'd0, 1'b0);
    // Stalled result while the next op waits on the input port.
    run_op(8'hDA, 2'b10, 4'd3, 4, 8'h3C, 2'b00, 4'd2, 1'b1);
    run_op(8'h3C, 2'b00, 4'd2, 0, 8'h00, 2'b00, 4'd0, 1'b0);

    // Reset two steps into a six-step shift.
    drive(8'h81, 2'b00, 4'd6, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    run_op(8'h6B, 2'b00, 4'd3, 1, 8'h00, 2'b00, 4'd0, 1'b0);

    cd = 8'($urandom);
    cm = 2'($urandom);
    cc = 4'($urandom);
    for (int i = 0; i < 40; i++) begin
      nd = 8'($urandom);
      nm = 2'($urandom);
      nc = 4'($urandom);
      run_op(cd, cm, cc, $urandom_range(0, 3), nd, nm, nc, 1'($urandom));
      cd = nd;
      cm = nm;
      cc = nc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
